mem_issue_queue: RTL and testbench

Parametrised in-order memory/system issue queue between the renamer and the LSU, the complex (mul/div) unit and the CSR/fence path. It buffers DEPTH packets of LANES micro-ops each and walks lanes in program order, skipping invalid lanes. Each cycle it issues at most one micro-op, once its operands are ready and its target channel can accept it. Non-speculative ops (CSR, FENCE) are serialised against the ROB head.

---
 rtl/mem_iq_pkg.sv | 42 ++++
 rtl/mem_iq_lane_pick.sv | 30 +++
 rtl/mem_issue_queue.sv | 152 +++++++++++++++
 tb/tb_mem_issue_queue.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_iq_pkg.sv
// Shared types and constants for the memory/system issue queue.
package mem_iq_pkg;

  localparam int IQ_XLEN  = 32;
  localparam int IQ_ROB_W = 5;
  localparam int IQ_LANES = 2;

  // Issue channel indices into chan_rdy_i / iss_vld_o
  localparam int CH_LSU  = 0;
  localparam int CH_CPLX = 1;
  localparam int CH_CSR  = 2;

  typedef enum logic [2:0] {
    CLS_LOAD  = 3'd0,
    CLS_STORE = 3'd1,
    CLS_CPLX  = 3'd2,
    CLS_CSR   = 3'd3,
    CLS_FENCE = 3'd4
  } cls_e;

  typedef struct packed {
    logic [5:0]         rs1;
    logic [5:0]         rs2;
    logic [5:0]         dest;
    logic [IQ_XLEN-1:0] imm;
    cls_e               cls;
    logic [2:0]         opc;
  } uop_t;

  // op = {is_store, opc}: the LSU shares one channel for loads and stores
  typedef struct packed {
    logic [3:0]                           op;
    logic [IQ_XLEN-1:0]                   addr;
    logic [IQ_XLEN-1:0]                   data;
    logic [5:0]                           dest;
    logic [IQ_ROB_W+$clog2(IQ_LANES)-1:0] rob;
  } iss_t;

  localparam int UOP_W = $bits(uop_t);
  localparam int ISS_W = $bits(iss_t);

endpackage

// File: rtl/mem_iq_lane_pick.sv
// Finds the lowest valid lane at or above lane_ptr; last means none follow it.
module mem_iq_lane_pick #(
  parameter  int LANES = 2,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0] lane_vld,
  input  logic [LW-1:0]    lane_ptr,
  output logic [LW-1:0]    sel,
  output logic             found,
  output logic             last
);

  // First hit selects; any later hit means the selected lane is not the last
  always_comb begin
    sel   = '0;
    found = 1'b0;
    last  = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (lane_vld[i] && (i >= int'(lane_ptr))) begin
        if (!found) begin
          sel   = LW'(i);
          found = 1'b1;
        end else begin
          last = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/mem_issue_queue.sv
// In-order issue queue feeding the LSU, complex unit and CSR/fence path.
module mem_issue_queue
  import mem_iq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LANES = IQ_LANES,
  parameter int ROB_W = IQ_ROB_W,
  parameter int XLEN  = IQ_XLEN
) (
  input  logic                            cpu_clk_i,
  input  logic                            cpu_rst_ni,
  input  logic                            flush_i,
  input  logic                            enq_vld_i,
  input  logic [ROB_W-1:0]                enq_rob_i,
  input  logic [LANES-1:0]                enq_lane_vld_i,
  input  logic [LANES*UOP_W-1:0]          enq_uop_i,
  output logic                            full_o,
  output logic [5:0]                      rs1_idx_o,
  output logic [5:0]                      rs2_idx_o,
  input  logic                            rs1_rdy_i,
  input  logic                            rs2_rdy_i,
  input  logic [XLEN-1:0]                 rs1_data_i,
  input  logic [XLEN-1:0]                 rs2_data_i,
  input  logic [ROB_W-1:0]                rob_oldest_i,
  input  logic                            rob_lock_i,
  input  logic [2:0]                      chan_rdy_i,
  input  logic                            sb_empty_i,
  input  logic                            sys_done_i,
  output logic [2:0]                      iss_vld_o,
  output iss_t                            iss_pkt_o,
  output logic                            fence_done_o,
  output logic [ROB_W+$clog2(LANES)-1:0]  fence_rob_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES-1:0][UOP_W-1:0] uop_q [DEPTH];
  logic [LANES-1:0]            vld_q [DEPTH];
  logic [ROB_W-1:0]            rob_q [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [LW-1:0] lane_ptr, sel;
  logic          sys_wait, fence_wait;
  logic          found, last;
  logic          push, pop, issue, retire, chan_ok, go, fence_fin;
  logic [2:0]    iss_ch;
  uop_t          head;
  logic [ROB_W-1:0] hrob;
  logic [ROB_W+LW-1:0] rob_id;
  iss_t          iss_d;

  mem_iq_lane_pick #(.LANES(LANES)) u_pick (
    .lane_vld (vld_q[rd_ptr]),
    .lane_ptr (lane_ptr),
    .sel      (sel),
    .found    (found),
    .last     (last)
  );

  assign head      = uop_t'(uop_q[rd_ptr][sel]);
  assign hrob      = rob_q[rd_ptr];
  assign rob_id    = {hrob, sel};
  assign rs1_idx_o = head.rs1;
  assign rs2_idx_o = head.rs2;

  // Issue decision, retirement and the outgoing packet for the head uop
  always_comb begin
    chan_ok = 1'b0;
    iss_ch  = '0;
    case (head.cls)
      CLS_LOAD:  begin chan_ok = chan_rdy_i[CH_LSU];                            iss_ch[CH_LSU]  = 1'b1; end
      CLS_STORE: begin chan_ok = rs2_rdy_i && chan_rdy_i[CH_LSU];               iss_ch[CH_LSU]  = 1'b1; end
      CLS_CPLX:  begin chan_ok = rs2_rdy_i && chan_rdy_i[CH_CPLX];              iss_ch[CH_CPLX] = 1'b1; end
      CLS_CSR:   begin chan_ok = chan_rdy_i[CH_CSR] && (hrob == rob_oldest_i);  iss_ch[CH_CSR]  = 1'b1; end
      CLS_FENCE: chan_ok = (hrob == rob_oldest_i);
      default:   chan_ok = 1'b0;
    endcase
    go        = (count != '0) && found && !rob_lock_i && !sys_wait && !fence_wait
                && rs1_rdy_i && !flush_i;
    issue     = go && chan_ok;
    fence_fin = fence_wait && sb_empty_i && !flush_i;
    // CSR and FENCE lanes retire on completion, not at issue
    retire    = !flush_i && ((issue && (head.cls inside {CLS_LOAD, CLS_STORE, CLS_CPLX}))
                || (sys_wait && sys_done_i) || fence_fin);
    pop       = retire && last;
    push      = enq_vld_i && !full_o && !flush_i && (|enq_lane_vld_i);
    count_nxt = count + CW'(push) - CW'(pop);

    iss_d      = '0;
    iss_d.op   = {head.cls == CLS_STORE, head.opc};
    iss_d.addr = rs1_data_i + head.imm;
    iss_d.dest = head.dest;
    iss_d.rob  = rob_id;
    if (head.cls == CLS_CSR)
      iss_d.data = head.opc[2] ? XLEN'(head.rs1[4:0]) :
                   head.opc[1] ? XLEN'(rs1_data_i[4:0]) : rs1_data_i;
    else
      iss_d.data = rs2_data_i;
  end

  // Packet storage; contents need no reset since count guards every read
  always_ff @(posedge cpu_clk_i) begin
    if (push) begin
      uop_q[wr_ptr] <= enq_uop_i;
      vld_q[wr_ptr] <= enq_lane_vld_i;
      rob_q[wr_ptr] <= enq_rob_i;
    end
  end

  // Pointers, occupancy and serialisation state
  always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
    if (!cpu_rst_ni) begin
      rd_ptr <= '0; wr_ptr <= '0; count <= '0; lane_ptr <= '0;
      sys_wait <= 1'b0; fence_wait <= 1'b0; full_o <= 1'b0;
    end else if (flush_i) begin
      rd_ptr <= '0; wr_ptr <= '0; count <= '0; lane_ptr <= '0;
      sys_wait <= 1'b0; fence_wait <= 1'b0; full_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        lane_ptr <= '0;
      end else if (retire) begin
        lane_ptr <= sel + LW'(1);
      end
      count  <= count_nxt;
      full_o <= (count_nxt == CW'(DEPTH));
      if (issue && head.cls == CLS_CSR) sys_wait <= 1'b1;
      else if (sys_done_i)              sys_wait <= 1'b0;
      if (issue && head.cls == CLS_FENCE) fence_wait <= 1'b1;
      else if (sb_empty_i)                fence_wait <= 1'b0;
    end
  end

  // Registered issue pulses and fence completion
  always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
    if (!cpu_rst_ni) begin
      iss_vld_o <= '0; iss_pkt_o <= '0; fence_done_o <= 1'b0; fence_rob_o <= '0;
    end else if (flush_i) begin
      iss_vld_o <= '0; fence_done_o <= 1'b0;
    end else begin
      iss_vld_o    <= issue ? iss_ch : 3'b000;
      if (issue) iss_pkt_o <= iss_d;
      fence_done_o <= fence_fin;
      if (fence_fin) fence_rob_o <= rob_id;
    end
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed bench with an in-order scoreboard of expected issue packets.
module tb_mem_issue_queue;
  import mem_iq_pkg::*;

  localparam int DEPTH = 8;
  localparam int LANES = 2;
  localparam int ROB_W = 5;
  localparam int XLEN  = 32;
  localparam int RW    = ROB_W + 1;

  logic cpu_clk_i, cpu_rst_ni, flush_i, enq_vld_i;
  logic [ROB_W-1:0] enq_rob_i, rob_oldest_i;
  logic [LANES-1:0] enq_lane_vld_i;
  logic [LANES*UOP_W-1:0] enq_uop_i;
  logic full_o, rs1_rdy_i, rs2_rdy_i, rob_lock_i, sb_empty_i, sys_done_i, fence_done_o;
  logic [5:0] rs1_idx_o, rs2_idx_o;
  logic [XLEN-1:0] rs1_data_i, rs2_data_i;
  logic [2:0] chan_rdy_i, iss_vld_o;
  iss_t iss_pkt_o;
  logic [RW-1:0] fence_rob_o;

  mem_issue_queue #(.DEPTH(DEPTH), .LANES(LANES), .ROB_W(ROB_W), .XLEN(XLEN)) dut (
    .cpu_clk_i(cpu_clk_i), .cpu_rst_ni(cpu_rst_ni), .flush_i(flush_i),
    .enq_vld_i(enq_vld_i), .enq_rob_i(enq_rob_i), .enq_lane_vld_i(enq_lane_vld_i),
    .enq_uop_i(enq_uop_i), .full_o(full_o), .rs1_idx_o(rs1_idx_o), .rs2_idx_o(rs2_idx_o),
    .rs1_rdy_i(rs1_rdy_i), .rs2_rdy_i(rs2_rdy_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .rob_oldest_i(rob_oldest_i), .rob_lock_i(rob_lock_i),
    .chan_rdy_i(chan_rdy_i), .sb_empty_i(sb_empty_i), .sys_done_i(sys_done_i),
    .iss_vld_o(iss_vld_o), .iss_pkt_o(iss_pkt_o), .fence_done_o(fence_done_o),
    .fence_rob_o(fence_rob_o)
  );

  typedef struct { logic [2:0] ch; iss_t pkt; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int n_chk = 0, n_pass = 0, n_iss = 0, n_fence = 0, n0;
  logic [RW-1:0] exp_fence;

  initial cpu_clk_i = 1'b0;
  always #5 cpu_clk_i = ~cpu_clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge cpu_clk_i);
    #2;
  endtask

  function automatic uop_t mk(cls_e c, logic [2:0] opc, logic [5:0] rs1, logic [5:0] dest,
                              logic [31:0] imm);
    uop_t u;
    u.rs1 = rs1; u.rs2 = rs1 + 6'd1; u.dest = dest; u.imm = imm; u.cls = c; u.opc = opc;
    return u;
  endfunction

  // Expected issue packet from the uop and the operand values the bench drives
  function automatic exp_t exp_of(uop_t u, logic [ROB_W-1:0] rob, logic lane);
    exp_t e;
    e.ch       = 3'b000;
    e.pkt.op   = {u.cls == CLS_STORE, u.opc};
    e.pkt.addr = rs1_data_i + u.imm;
    e.pkt.data = rs2_data_i;
    e.pkt.dest = u.dest;
    e.pkt.rob  = {rob, lane};
    case (u.cls)
      CLS_LOAD, CLS_STORE: e.ch = 3'b001;
      CLS_CPLX:            e.ch = 3'b010;
      CLS_CSR: begin
        e.ch = 3'b100;
        e.pkt.data = u.opc[2] ? {27'b0, u.rs1[4:0]} :
                     u.opc[1] ? {27'b0, rs1_data_i[4:0]} : rs1_data_i;
      end
      default: e.ch = 3'b000;
    endcase
    return e;
  endfunction

  task automatic enq(input logic [ROB_W-1:0] rob, input logic [1:0] lv,
                     input uop_t u0, input uop_t u1, input bit accept);
    enq_vld_i = 1'b1; enq_rob_i = rob; enq_lane_vld_i = lv; enq_uop_i = {u1, u0};
    if (accept) begin
      if (lv[0] && u0.cls != CLS_FENCE) sb.push_back(exp_of(u0, rob, 1'b0));
      if (lv[1] && u1.cls != CLS_FENCE) sb.push_back(exp_of(u1, rob, 1'b1));
    end
    step();
    enq_vld_i = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && sb.size() != 0; i++) step();
    step();
    chk("drain", 128'(sb.size()), 128'(0));
  endtask

  // Output monitor: every issue pulse must match the head of the scoreboard
  always @(negedge cpu_clk_i) begin
    if (cpu_rst_ni) begin
      if (iss_vld_o != 3'b000) begin
        n_iss++;
        if (sb.size() == 0) begin
          chk("unexpected_issue", 128'(iss_vld_o), 128'(0));
        end else begin
          mon_e = sb.pop_front();
          chk("iss_ch", 128'(iss_vld_o), 128'(mon_e.ch));
          chk("iss_pkt", 128'(iss_pkt_o), 128'(mon_e.pkt));
        end
      end
      if (fence_done_o) begin
        n_fence++;
        chk("fence_rob", 128'(fence_rob_o), 128'(exp_fence));
      end
    end
  end

  initial begin
    cpu_rst_ni = 1'b0; flush_i = 1'b0; enq_vld_i = 1'b0; enq_rob_i = '0;
    enq_lane_vld_i = '0; enq_uop_i = '0; rs1_rdy_i = 1'b1; rs2_rdy_i = 1'b1;
    rs1_data_i = 32'h100; rs2_data_i = 32'hCAFE_F00D; rob_oldest_i = '0;
    rob_lock_i = 1'b0; chan_rdy_i = 3'b111; sb_empty_i = 1'b1; sys_done_i = 1'b0;
    exp_fence = '0;
    repeat (3) step();
    chk("rst_iss_vld", 128'(iss_vld_o), 128'(0));
    chk("rst_full", 128'(full_o), 128'(0));
    chk("rst_fence", 128'(fence_done_o), 128'(0));
    chk("rst_pkt", 128'(iss_pkt_o), 128'(0));
    cpu_rst_ni = 1'b1;
    step();

    // Two-lane packet, LOAD then STORE: pulses two and three cycles out
    enq(5'd3, 2'b11, mk(CLS_LOAD, 3'd2, 6'd1, 6'd10, 32'h8),
                     mk(CLS_STORE, 3'd1, 6'd2, 6'd11, 32'h20), 1'b1);
    chk("t1_c1_idle", 128'(iss_vld_o), 128'(0));
    step();
    chk("t1_c2_lsu", 128'(iss_vld_o), 128'(3'b001));
    chk("t1_c2_addr", 128'(iss_pkt_o.addr), 128'(32'h108));
    chk("t1_c2_rob", 128'(iss_pkt_o.rob), 128'(6));
    step();
    chk("t1_c3_lsu", 128'(iss_vld_o), 128'(3'b001));
    chk("t1_c3_rob", 128'(iss_pkt_o.rob), 128'(7));
    step();
    chk("t1_idle", 128'(iss_vld_o), 128'(0));
    chk("t1_count", 128'(dut.count), 128'(0));

    // Lane 0 invalid, held by ROB lock first; then an all-invalid packet
    n0 = n_iss;
    rob_lock_i = 1'b1;
    enq(5'd9, 2'b10, mk(CLS_LOAD, 3'd0, 6'd3, 6'd12, 32'h0),
                     mk(CLS_CPLX, 3'd3, 6'd4, 6'd13, 32'h0), 1'b1);
    repeat (4) step();
    chk("t2_lock", 128'(n_iss), 128'(n0));
    rob_lock_i = 1'b0;
    wait_drain(6);
    chk("t2_one_issue", 128'(n_iss), 128'(n0 + 1));
    enq(5'd10, 2'b00, mk(CLS_LOAD, 3'd0, 6'd5, 6'd14, 32'h4),
                      mk(CLS_LOAD, 3'd0, 6'd6, 6'd15, 32'h4), 1'b0);
    repeat (3) step();
    chk("t2_empty_pkt", 128'(dut.count), 128'(0));
    chk("t2_no_issue", 128'(n_iss), 128'(n0 + 1));

    // Fill with channels blocked, drop a ninth packet, then drain with wrap
    chan_rdy_i = 3'b000;
    for (int k = 0; k < DEPTH; k++)
      enq(5'(k), 2'b11, mk(CLS_LOAD, 3'd0, 6'(k), 6'(20 + k), 32'(k * 16)),
                        mk(CLS_STORE, 3'd0, 6'(k + 8), 6'(40 + k), 32'(k * 16 + 4)), 1'b1);
    chk("t3_full", 128'(full_o), 128'(1));
    enq(5'd20, 2'b11, mk(CLS_LOAD, 3'd0, 6'd30, 6'd60, 32'h0),
                      mk(CLS_LOAD, 3'd0, 6'd31, 6'd61, 32'h0), 1'b0);
    chk("t3_drop", 128'(dut.count), 128'(DEPTH));
    chan_rdy_i = 3'b111;
    wait_drain(40);
    chk("t3_count", 128'(dut.count), 128'(0));
    chk("t3_not_full", 128'(full_o), 128'(0));

    // CSR serialisation against the ROB head
    rs1_data_i = 32'h137;
    rob_oldest_i = 5'd4;
    n0 = n_iss;
    enq(5'd5, 2'b11, mk(CLS_CSR, 3'b100, 6'h2A, 6'd16, 32'h0),
                     mk(CLS_CSR, 3'b010, 6'd7, 6'd17, 32'h0), 1'b1);
    sys_done_i = 1'b1;
    step();
    sys_done_i = 1'b0;
    repeat (4) step();
    chk("t4_not_oldest", 128'(n_iss), 128'(n0));
    rob_oldest_i = 5'd5;
    repeat (5) step();
    chk("t4_stall", 128'(n_iss), 128'(n0 + 1));
    sys_done_i = 1'b1;
    step();
    sys_done_i = 1'b0;
    repeat (4) step();
    chk("t4_second", 128'(n_iss), 128'(n0 + 2));
    sys_done_i = 1'b1;
    step();
    sys_done_i = 1'b0;
    step();
    chk("t4_count", 128'(dut.count), 128'(0));

    // FENCE waits for the store buffer to drain
    sb_empty_i = 1'b0;
    rob_oldest_i = 5'd6;
    exp_fence = {5'd6, 1'b0};
    enq(5'd6, 2'b01, mk(CLS_FENCE, 3'd0, 6'd0, 6'd0, 32'h0),
                     mk(CLS_LOAD, 3'd0, 6'd0, 6'd0, 32'h0), 1'b1);
    repeat (10) step();
    chk("t5_no_fence", 128'(n_fence), 128'(0));
    chk("t5_held", 128'(dut.count), 128'(1));
    sb_empty_i = 1'b1;
    repeat (4) step();
    chk("t5_fence_once", 128'(n_fence), 128'(1));
    chk("t5_count", 128'(dut.count), 128'(0));

    // Flush while a CSR is outstanding with five packets queued
    rob_oldest_i = 5'd7;
    enq(5'd7, 2'b01, mk(CLS_CSR, 3'b000, 6'd9, 6'd18, 32'h0),
                     mk(CLS_LOAD, 3'd0, 6'd0, 6'd0, 32'h0), 1'b1);
    repeat (3) step();
    for (int k = 0; k < 4; k++)
      enq(5'(8 + k), 2'b11, mk(CLS_LOAD, 3'd0, 6'd1, 6'd19, 32'h0),
                            mk(CLS_LOAD, 3'd0, 6'd2, 6'd19, 32'h0), 1'b0);
    chk("t6_count5", 128'(dut.count), 128'(5));
    chk("t6_sys_wait", 128'(dut.sys_wait), 128'(1));
    n0 = n_iss;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("t6_flush_count", 128'(dut.count), 128'(0));
    chk("t6_flush_vld", 128'(iss_vld_o), 128'(0));
    repeat (2) step();
    sys_done_i = 1'b1;
    step();
    sys_done_i = 1'b0;
    repeat (3) step();
    chk("t6_no_issue", 128'(n_iss), 128'(n0));
    enq(5'd12, 2'b01, mk(CLS_LOAD, 3'd5, 6'd3, 6'd21, 32'hFFFF_FFF0),
                      mk(CLS_LOAD, 3'd0, 6'd0, 6'd0, 32'h0), 1'b1);
    wait_drain(6);
    chk("t6_count", 128'(dut.count), 128'(0));
    chk("sb_left", 128'(sb.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
